// File: rtl/mtr_pwm_decode_if.sv
`default_nettype none
// ============================================================================
// Module      : mtr_pwm_decode_if
// Description : PWM-pair inputs and decoded speed/direction/fault outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface mtr_pwm_decode_if #(
    parameter int W = 11
);
    logic         PWM_frwrd;
    logic         PWM_rev;
    logic         clr_flt;
    logic [W-1:0] spd;
    logic         rev;
    logic         vld;
    logic         mixed;
    logic         shoot_thru;

    modport master (
        output PWM_frwrd, PWM_rev, clr_flt,
        input  spd, rev, vld, mixed, shoot_thru
    );

    modport slave (
        input  PWM_frwrd, PWM_rev, clr_flt,
        output spd, rev, vld, mixed, shoot_thru
    );
endinterface
`default_nettype wire

// File: rtl/mtr_pwm_decode.sv
`default_nettype none
// ============================================================================
// Module      : mtr_pwm_decode
// Description : Decodes speed magnitude/direction from a fwd/rev PWM pair over
//               a 2^W-clock window and flags shoot-through.
// Revision    : 1.0 - initial release
// ============================================================================
module mtr_pwm_decode #(
    parameter int W = 11
) (
    input  wire logic        clk,
    input  wire logic        rst,
    mtr_pwm_decode_if.slave  bus
);

    localparam logic [W-1:0] c_win_last = {W{1'b1}};
    localparam logic [W-1:0] c_win_one  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W:0]   c_cnt_zero = {(W+1){1'b0}};

    logic         r_f_meta, r_f_s;
    logic         r_r_meta, r_r_s;
    logic [W-1:0] r_win_cnt;
    logic [W:0]   r_f_cnt, r_r_cnt;
    logic [W-1:0] r_spd;
    logic         r_rev, r_vld, r_mixed, r_shoot_thru;

    logic         w_win_end;
    logic [W:0]   w_f_fin, w_r_fin, w_max;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_f_meta <= 1'b0;
            r_f_s    <= 1'b0;
            r_r_meta <= 1'b0;
            r_r_s    <= 1'b0;
        end else begin
            r_f_meta <= bus.PWM_frwrd;
            r_f_s    <= r_f_meta;
            r_r_meta <= bus.PWM_rev;
            r_r_s    <= r_r_meta;
        end
    end

    // Final counts include the end-of-window sample itself.
    assign w_win_end = (r_win_cnt == c_win_last);
    assign w_f_fin   = r_f_cnt + {{W{1'b0}}, r_f_s};
    assign w_r_fin   = r_r_cnt + {{W{1'b0}}, r_r_s};
    assign w_max     = (w_r_fin > w_f_fin) ? w_r_fin : w_f_fin;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_win_cnt <= {W{1'b0}};
            r_f_cnt   <= c_cnt_zero;
            r_r_cnt   <= c_cnt_zero;
            r_spd     <= {W{1'b0}};
            r_rev     <= 1'b0;
            r_vld     <= 1'b0;
            r_mixed   <= 1'b0;
        end else begin
            r_win_cnt <= r_win_cnt + c_win_one;
            r_vld     <= w_win_end;
            if (w_win_end) begin
                r_f_cnt <= c_cnt_zero;
                r_r_cnt <= c_cnt_zero;
                r_rev   <= (w_r_fin > w_f_fin);
                r_spd   <= w_max[W] ? {W{1'b1}} : w_max[W-1:0];
                r_mixed <= (w_f_fin != c_cnt_zero) && (w_r_fin != c_cnt_zero);
            end else begin
                r_f_cnt <= w_f_fin;
                r_r_cnt <= w_r_fin;
            end
        end
    end

    // A live overlap outranks a clear request in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shoot_thru <= 1'b0;
        end else if (r_f_s && r_r_s) begin
            r_shoot_thru <= 1'b1;
        end else if (bus.clr_flt) begin
            r_shoot_thru <= 1'b0;
        end
    end

    assign bus.spd        = r_spd;
    assign bus.rev        = r_rev;
    assign bus.vld        = r_vld;
    assign bus.mixed      = r_mixed;
    assign bus.shoot_thru = r_shoot_thru;

endmodule
`default_nettype wire

// File: tb/tb_mtr_pwm_decode.sv
`default_nettype none
// ============================================================================
// Module      : tb_mtr_pwm_decode
// Description : Self-checking bench for mtr_pwm_decode against a window model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mtr_pwm_decode;

    localparam int c_w   = 11;
    localparam int c_win = 2048;

    logic clk;
    logic rst;

    mtr_pwm_decode_if #(.W(c_w)) bus ();

    mtr_pwm_decode #(.W(c_w)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state: pin history and per-window high-time totals.
    int   m_n;
    bit   m_hf[$];
    bit   m_hr[$];
    int   m_acc_f, m_acc_r;
    logic [31:0] e_spd;
    logic e_rev, e_vld, e_mixed, e_st;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h at n=%0d", tag, obs, exp, m_n);
        end
    endtask

    task automatic model_update(input bit f, input bit r, input bit c, input bit rs);
        bit sf, sr;
        int mx;
        if (rs) begin
            m_n = 0;
            m_hf.delete();
            m_hr.delete();
            m_acc_f = 0;
            m_acc_r = 0;
            e_spd = 0; e_rev = 0; e_vld = 0; e_mixed = 0; e_st = 0;
        end else begin
            sf = 1'b0;
            sr = 1'b0;
            if (m_hf.size() == 2) begin
                sf = m_hf.pop_front();
                sr = m_hr.pop_front();
            end
            m_hf.push_back(f);
            m_hr.push_back(r);
            m_acc_f += int'(sf);
            m_acc_r += int'(sr);
            e_vld = ((m_n % c_win) == c_win - 1);
            if (e_vld) begin
                mx      = (m_acc_f > m_acc_r) ? m_acc_f : m_acc_r;
                e_spd   = (mx > c_win - 1) ? (c_win - 1) : mx;
                e_rev   = (m_acc_r > m_acc_f);
                e_mixed = (m_acc_f != 0) && (m_acc_r != 0);
                m_acc_f = 0;
                m_acc_r = 0;
            end
            if (sf && sr) e_st = 1'b1;
            else if (c)   e_st = 1'b0;
            m_n++;
        end
    endtask

    task automatic step(input bit f, input bit r, input bit c, input bit rs);
        bus.PWM_frwrd = f;
        bus.PWM_rev   = r;
        bus.clr_flt   = c;
        rst           = rs;
        @(posedge clk);
        model_update(f, r, c, rs);
        #1;
        chk("vld",        {31'd0, bus.vld},        {31'd0, e_vld});
        chk("spd",        {21'd0, bus.spd},        e_spd);
        chk("rev",        {31'd0, bus.rev},        {31'd0, e_rev});
        chk("mixed",      {31'd0, bus.mixed},      {31'd0, e_mixed});
        chk("shoot_thru", {31'd0, bus.shoot_thru}, {31'd0, e_st});
    endtask

    // Steady PWM on one leg; two extra steps guarantee a fully-steady last window.
    task automatic run_pwm(input int duty, input bit dir, input int nwin, input int phase);
        bit h;
        for (int t = 0; t < nwin * c_win + 2; t++) begin
            h = (((t + phase) % c_win) < duty);
            step(dir ? 1'b0 : h, dir ? h : 1'b0, 1'b0, 1'b0);
        end
    endtask

    int vcnt;
    int duty;
    bit dir;

    initial begin
        bus.PWM_frwrd = 1'b0;
        bus.PWM_rev   = 1'b0;
        bus.clr_flt   = 1'b0;
        rst           = 1'b1;
        m_n = 0; m_acc_f = 0; m_acc_r = 0;
        e_spd = 0; e_rev = 0; e_vld = 0; e_mixed = 0; e_st = 0;

        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("reset_spd",  {21'd0, bus.spd}, 32'd0);
        chk("reset_flag", {28'd0, bus.vld, bus.rev, bus.mixed, bus.shoot_thru}, 32'd0);

        run_pwm(0, 1'b0, 2, 0);
        run_pwm(0, 1'b1, 2, 0);
        chk("zero_spd", {21'd0, bus.spd}, 32'd0);

        run_pwm(2047, 1'b0, 2, 300);
        chk("full_fwd_spd", {21'd0, bus.spd}, 32'h7FF);
        chk("full_fwd_rev", {31'd0, bus.rev}, 32'd0);
        run_pwm(2047, 1'b1, 2, 1234);
        chk("full_rev_spd", {21'd0, bus.spd}, 32'h7FF);
        chk("full_rev_rev", {31'd0, bus.rev}, 32'd1);

        run_pwm(32'h1FF, 1'b1, 2, 77);
        chk("med_spd", {21'd0, bus.spd}, 32'h1FF);
        chk("med_rev", {31'd0, bus.rev}, 32'd1);

        run_pwm(c_win, 1'b0, 2, 0);
        chk("sat_spd", {21'd0, bus.spd}, 32'h7FF);
        chk("sat_rev", {31'd0, bus.rev}, 32'd0);

        for (int k = 0; k < 3; k++) begin
            duty = int'($urandom_range(0, c_win));
            dir  = 1'($urandom_range(0, 1));
            run_pwm(duty, dir, 2, int'($urandom_range(0, c_win - 1)));
            chk("rand_spd", {21'd0, bus.spd}, (duty > c_win - 1) ? 32'h7FF : 32'(duty));
            chk("rand_rev", {31'd0, bus.rev}, {31'd0, dir && (duty != 0)});
        end

        step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("st_set", {31'd0, bus.shoot_thru}, 32'd1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("st_sticky", {31'd0, bus.shoot_thru}, 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("st_clr", {31'd0, bus.shoot_thru}, 32'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("st_set_wins", {31'd0, bus.shoot_thru}, 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("st_clr2", {31'd0, bus.shoot_thru}, 32'd0);

        // Get nonzero outputs and a set fault, then reset at window cycle 1000.
        step(1'b1, 1'b1, 1'b0, 1'b0);
        while ((m_n % c_win) != 1000) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("rst_mid_spd",  {21'd0, bus.spd}, 32'd0);
        chk("rst_mid_flag", {28'd0, bus.vld, bus.rev, bus.mixed, bus.shoot_thru}, 32'd0);
        vcnt = 0;
        for (int i = 0; i < c_win; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            if (i < c_win - 1 && bus.vld) vcnt++;
        end
        chk("rst_no_early_vld", 32'(vcnt), 32'd0);
        chk("rst_first_vld", {31'd0, bus.vld}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
